// File: rtl/shfl_iter.sv
// ---------------------------------------------------------------------------
// shfl_iter
//
// Iterative 16-bit left shifter / rotator for the execute stage. An operand,
// a 4-bit shift count and an operation select are captured on an accepted
// start strobe. The datapath then moves one bit position per clock. When the
// last position has been shifted, a one-cycle done pulse is raised and the
// result is presented on Out. The execute stage stalls on busy while this is
// in progress, trading latency for a very small datapath.
//
// Ports
//   clk      in   1  system clock, all state changes on the rising edge
//   rst      in   1  synchronous active-high reset
//   in       in  16  operand, sampled only when a start is accepted
//   bit_cnt  in   4  shift amount 0..15, sampled with in
//   op       in   1  0 = shift left logical (zero fill), 1 = rotate left
//   start    in   1  request strobe, accepted only while idle
//   Out      out 16  result register, updated on entry to the done cycle
//   busy     out  1  high while shifting and during the done cycle
//   done     out  1  one-cycle pulse, Out is valid
//   err      out  1  one-cycle pulse, a start arrived while busy
// ---------------------------------------------------------------------------
module shfl_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in,
    input  logic [3:0]  bit_cnt,
    input  logic        op,
    input  logic        start,
    output logic [15:0] Out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Architectural state and registered outputs
    state_t      state_q,  state_d;
    logic [15:0] data_q,   data_d;
    logic [3:0]  remCnt_q, remCnt_d;
    logic        opRot_q,  opRot_d;
    logic [15:0] out_q,    out_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;
    logic        err_q,    err_d;

    // One position of movement. A rotate feeds the bit leaving the top back
    // into bit 0; a logical shift brings in a zero.
    logic [15:0] stepData;

    always_comb begin
        stepData = {data_q[14:0], (opRot_q & data_q[15])};
    end

    // Next-state logic for the whole block. Outputs are computed from the
    // next state so that busy/done/err come straight out of flops.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        remCnt_d = remCnt_q;
        opRot_d  = opRot_q;
        out_d    = out_q;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d   = in;
                    remCnt_d = bit_cnt;
                    opRot_d  = op;
                    if (bit_cnt == 4'd0) begin
                        // Nothing to move: the operand itself is the result.
                        state_d = DONE;
                        out_d   = in;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                data_d = stepData;
                err_d  = start;
                if (remCnt_q == 4'd1) begin
                    // Final position: publish the shifted word as it lands.
                    state_d = DONE;
                    out_d   = stepData;
                end else begin
                    remCnt_d = remCnt_q - 4'd1;
                end
            end

            DONE: begin
                // A start here is reported but not queued.
                err_d   = start;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Single state register. Reset wins over any start seen in the same cycle
    // and aborts an operation in flight without producing a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= 16'h0000;
            remCnt_q <= 4'd0;
            opRot_q  <= 1'b0;
            out_q    <= 16'h0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            remCnt_q <= remCnt_d;
            opRot_q  <= opRot_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign Out  = out_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_shfl_iter.sv
// ---------------------------------------------------------------------------
// tb_shfl_iter
//
// Self-checking bench for shfl_iter. Expected results come from a word-level
// model: a left shift by n is the low half of the 32-bit product with 2^n,
// and a rotate additionally folds the high half back in.
// ---------------------------------------------------------------------------
module tb_shfl_iter;

    logic        clk;
    logic        rst;
    logic [15:0] in;
    logic [3:0]  bit_cnt;
    logic        op;
    logic        start;
    logic [15:0] Out;
    logic        busy;
    logic        done;
    logic        err;

    int compared   = 0;
    int mismatched = 0;

    shfl_iter dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .bit_cnt (bit_cnt),
        .op      (op),
        .start   (start),
        .Out     (Out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-level reference: shift into a 32-bit field, rotate wraps the
    // overflow half back into the low half.
    function automatic logic [15:0] refShift(input logic [15:0] a, input int n,
                                             input logic rot);
        logic [31:0] wide;
        wide = {16'h0000, a} << n;
        if (rot) return wide[15:0] | wide[31:16];
        return wide[15:0];
    endfunction

    // Advance one clock; observation point is 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and observe it until the block returns to idle.
    // Only gathers observations; each test does its own comparisons.
    task automatic runOp(input logic [15:0] a, input logic [3:0] n, input logic rot,
                         input bit scramble, output int doneAt, output int busyCycles,
                         output int doneCount, output logic [15:0] res);
        in      = a;
        bit_cnt = n;
        op      = rot;
        start   = 1'b1;
        step();
        start      = 1'b0;
        doneAt     = -1;
        busyCycles = 0;
        doneCount  = 0;
        res        = 16'h0000;
        for (int k = 1; k <= 24; k++) begin
            if (busy) busyCycles++;
            if (done) begin
                doneCount++;
                if (doneAt < 0) begin
                    doneAt = k;
                    res    = Out;
                end
            end
            if (!busy && doneAt >= 0) break;
            if (scramble) begin
                in      = 16'($urandom);
                bit_cnt = 4'($urandom);
                op      = 1'($urandom);
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        in    = 16'hA5A5;
        bit_cnt = 4'd3;
        op    = 1'b1;
        step();
        step();
        compared++;
        if (Out !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL reset_out: got %h expected 0000", Out);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_done: got %b expected 0", done);
        end
        compared++;
        if (err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_err: got %b expected 0", err);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_vectors();
        logic [15:0] vecIn  [5] = '{16'h1234, 16'h8001, 16'hF00F, 16'h0001, 16'hBEEF};
        logic [3:0]  vecN   [5] = '{4'd4, 4'd1, 4'd15, 4'd15, 4'd0};
        logic        vecRot [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] vecExp [5] = '{16'h2340, 16'h0003, 16'hF807, 16'h8000, 16'hBEEF};
        int doneAt, busyCycles, doneCount;
        logic [15:0] res;
        for (int i = 0; i < 5; i++) begin
            runOp(vecIn[i], vecN[i], vecRot[i], 1'b0, doneAt, busyCycles, doneCount, res);
            compared++;
            if (res !== vecExp[i]) begin
                mismatched++;
                $display("[TB] FAIL vec%0d_result: got %h expected %h", i, res, vecExp[i]);
            end
            compared++;
            if (doneAt != int'(vecN[i]) + 1) begin
                mismatched++;
                $display("[TB] FAIL vec%0d_latency: got %0d expected %0d", i, doneAt,
                         int'(vecN[i]) + 1);
            end
            compared++;
            if (busyCycles != int'(vecN[i]) + 1 || doneCount != 1) begin
                mismatched++;
                $display("[TB] FAIL vec%0d_busy: got busy=%0d dones=%0d expected busy=%0d dones=1",
                         i, busyCycles, doneCount, int'(vecN[i]) + 1);
            end
        end
    endtask

    // Random operands with inputs scrambled every cycle during the operation;
    // only the values sampled at acceptance may affect the result.
    task automatic test_random();
        int doneAt, busyCycles, doneCount;
        logic [15:0] res, a, expv;
        logic [3:0]  n;
        logic        rot;
        for (int i = 0; i < 20; i++) begin
            a    = 16'($urandom);
            n    = 4'($urandom);
            rot  = 1'($urandom);
            expv = refShift(a, int'(n), rot);
            runOp(a, n, rot, 1'b1, doneAt, busyCycles, doneCount, res);
            compared++;
            if (res !== expv || doneAt != int'(n) + 1 || doneCount != 1) begin
                mismatched++;
                $display("[TB] FAIL rand%0d: a=%h n=%0d rot=%b got %h at %0d (%0d dones) expected %h at %0d",
                         i, a, n, rot, res, doneAt, doneCount, expv, int'(n) + 1);
            end
        end
    endtask

    // Second request issued in the first idle cycle after the first one.
    task automatic test_back_to_back();
        int doneAt, busyCycles, doneCount;
        logic [15:0] res;
        runOp(16'h00F0, 4'd3, 1'b1, 1'b0, doneAt, busyCycles, doneCount, res);
        compared++;
        if (res !== refShift(16'h00F0, 3, 1'b1) || doneAt != 4) begin
            mismatched++;
            $display("[TB] FAIL b2b_first: got %h at %0d expected %h at 4", res, doneAt,
                     refShift(16'h00F0, 3, 1'b1));
        end
        runOp(16'hC003, 4'd2, 1'b1, 1'b0, doneAt, busyCycles, doneCount, res);
        compared++;
        if (res !== 16'h000F || doneAt != 3) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: got %h at %0d expected 000f at 3", res, doneAt);
        end
    endtask

    // Starts while busy: err pulses next cycle, result and done count unaffected,
    // and a start during the done cycle is not queued.
    task automatic test_err();
        int doneCount, doneAt;
        logic [15:0] res;
        in = 16'h1234; bit_cnt = 4'd4; op = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        doneCount = 0;
        doneAt    = -1;
        res       = 16'h0000;
        for (int k = 1; k <= 24; k++) begin
            if (k == 2) begin
                in = 16'hFFFF; bit_cnt = 4'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (k == 3) begin
                compared++;
                if (err !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL err_pulse: got %b expected 1", err);
                end
            end
            if (k == 4) begin
                compared++;
                if (err !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL err_width: got %b expected 0", err);
                end
            end
            if (done) begin
                doneCount++;
                if (doneAt < 0) begin
                    doneAt = k;
                    res    = Out;
                end
            end
            if (!busy && k > 1) break;
            step();
        end
        start = 1'b0;
        compared++;
        if (res !== 16'h2340 || doneCount != 1 || doneAt != 5) begin
            mismatched++;
            $display("[TB] FAIL err_result: got %h dones=%0d at %0d expected 2340 dones=1 at 5",
                     res, doneCount, doneAt);
        end

        // Start presented during the done cycle.
        in = 16'h0003; bit_cnt = 4'd2; op = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 8 && !done; k++) step();
        start = 1'b1;
        in    = 16'h7777;
        step();
        start = 1'b0;
        compared++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL err_in_done: got err=%b busy=%b expected err=1 busy=0", err, busy);
        end
        step();
        compared++;
        if (busy !== 1'b0 || Out !== 16'h000C) begin
            mismatched++;
            $display("[TB] FAIL done_not_queued: got busy=%b out=%h expected busy=0 out=000c",
                     busy, Out);
        end
    endtask

    // Reset in the middle of a shift aborts it, and reset beats start.
    task automatic test_reset_mid();
        int doneAt, busyCycles, doneCount;
        logic [15:0] res;
        int lateDones;
        in = 16'h00FF; bit_cnt = 4'd8; op = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        compared++;
        if (busy !== 1'b0 || Out !== 16'h0000 || done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_abort: got busy=%b out=%h done=%b expected busy=0 out=0000 done=0",
                     busy, Out, done);
        end
        lateDones = 0;
        for (int k = 0; k < 10; k++) begin
            if (done || busy) lateDones++;
            step();
        end
        compared++;
        if (lateDones != 0) begin
            mismatched++;
            $display("[TB] FAIL rst_no_done: got %0d active cycles expected 0", lateDones);
        end

        rst = 1'b1; start = 1'b1; in = 16'h1111; bit_cnt = 4'd0;
        step();
        rst = 1'b0; start = 1'b0;
        step();
        compared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_priority: got busy=%b done=%b expected 0 0", busy, done);
        end

        runOp(16'h00FF, 4'd8, 1'b0, 1'b0, doneAt, busyCycles, doneCount, res);
        compared++;
        if (res !== 16'hFF00 || doneAt != 9) begin
            mismatched++;
            $display("[TB] FAIL rst_fresh: got %h at %0d expected ff00 at 9", res, doneAt);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in = '0; bit_cnt = '0; op = 1'b0;
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shfl_iter.md
# shfl_iter

Iterative left shifter/rotator for the execute stage: the left-direction counterpart of the single-cycle arithmetic right shifter. It accepts a 16-bit operand, a 4-bit shift count and an operation select on a start strobe. It then performs one bit position per clock and raises a one-cycle done pulse with the result held on `Out`. The execute stage uses it where area matters more than latency, and stalls on `busy`.

## Interface
- No parameters; data width fixed at 16, count width fixed at 4.
- `clk` input 1: single system clock; all state changes on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in` input 16: operand, sampled only when a start is accepted.
- `bit_cnt` input 4: shift amount 0–15, sampled with `in`.
- `op` input 1: 0 = shift left logical (zero fill), 1 = rotate left; sampled with `in`.
- `start` input 1: request strobe; accepted only in IDLE.
- `Out` output 16: result register; valid from the done cycle and held until the next accepted start.
- `busy` output 1: high in SHIFT and DONE states.
- `done` output 1: one-cycle pulse, result valid.
- `err` output 1: one-cycle pulse when `start` is seen while `busy`=1.

## Operation
- States are IDLE, SHIFT and DONE. Internal registers are the data register, the 4-bit remaining count and the latched op.
- IDLE with `start`=1 (accept):
  - Load the data register with `in`, remaining with `bit_cnt`, and latch `op`.
  - Next state is DONE if `bit_cnt`=0, else SHIFT.
- SHIFT:
  - Each cycle, the data register becomes {d[14:0], 0} for SLL or {d[14:0], d[15]} for ROL.
  - Remaining decrements by 1.
  - When remaining=1 at the edge, the final shift is performed and the next state is DONE.
- DONE: `done`=1 for exactly this cycle. `Out` is driven from the data register. Next state is IDLE unconditionally.
- `start` in SHIFT or DONE:
  - Ignored; operand registers are unaffected.
  - `err` pulses in the following cycle.
  - A start in DONE is not queued; the requester must retry in IDLE.
- `in`, `bit_cnt` and `op` may change freely after acceptance; the block never re-samples them mid-operation.
- `Out` is registered (updated on entry to DONE) and holds through IDLE until the next result.
- Count arithmetic is unsigned 4-bit with no wrap: remaining never decrements below 1 in SHIFT.

## Timing
- Reset values: state=IDLE, `Out`=0x0000, `busy`=0, `done`=0, `err`=0, internal registers 0.
- Reset mid-operation aborts the operation. The next cycle is IDLE with all outputs at reset values, and no `done` pulse is issued for the aborted request.
- Reset has priority over `start` in the same cycle.
- Latency: with start accepted at edge E0, `done` is high in cycle E0+N+1 for N=`bit_cnt`. For N=0 that is the cycle immediately after E0; for N=15 it is E0+16.
- `busy` rises the cycle after acceptance and falls in the cycle after `done`. A new start is accepted at the earliest in the cycle following the done pulse.
- `err` is registered: a start seen in cycle k while busy gives `err`=1 in cycle k+1.
- Throughput: one operation per N+2 cycles maximum.

## Test plan
- Reset, then SLL `in`=0x1234, `bit_cnt`=4 -> `busy`=1 for 5 cycles, `done` pulse at E0+5, `Out`=0x2340.
- ROL `in`=0x8001, `bit_cnt`=1 -> `done` at E0+2, `Out`=0x0003. ROL 0xF00F by 15 -> `Out`=0xF807 at E0+16.
- SLL 0x0001 by 15 -> 0x8000. SLL 0xBEEF by 0 -> `done` at E0+1, `Out`=0xBEEF. Back-to-back starts in consecutive IDLE windows both complete with correct results.
- Start during SHIFT with different operand (0xFFFF by 1) -> `err` pulse next cycle, original result unchanged, no extra `done`.
- Assert `rst` during SHIFT of 0x00FF by 8 -> next cycle `busy`=0 and `Out`=0x0000, no `done`. A fresh SLL 0x00FF by 8 then yields 0xFF00.
- Change `in`/`bit_cnt`/`op` every cycle during an operation -> result reflects only the values sampled at acceptance.
